// File: rtl/stat_pkg.sv
// rtl/stat_pkg.sv - shared constants and state type for the statistics result packetizer
package stat_pkg;
  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int         PKT_LEN             = 11;
  localparam logic [3:0] CSUM_IDX            = 4'd10;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/stat_result_packetizer_if.sv
// rtl/stat_result_packetizer_if.sv - byte stream from the packetizer to the Ethernet sender
interface stat_result_packetizer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/stat_result_packetizer.sv
// rtl/stat_result_packetizer.sv - frames one mean/sd/variance result as an 11-byte packet
// and streams it out with a running checksum; every output is registered.
module stat_result_packetizer
  import stat_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        result_valid,
  input  logic [15:0] mean_in,
  input  logic [15:0] sd_in,
  input  logic [31:0] var_in,
  output logic        result_ready,
  output logic        data_sent,
  output logic [7:0]  seq_num,
  output logic [7:0]  drop_count,
  stat_result_packetizer_if.master tx
);
  state_t      state, state_next;
  logic [3:0]  idx, idx_next;
  logic [7:0]  csum, csum_next;
  logic [15:0] mean_q, sd_q;
  logic [31:0] var_q;
  logic [7:0]  seq_q;
  logic        latch;
  logic [7:0]  data_next, seq_next, drop_next;
  logic        valid_next, last_next, sent_next;

  function automatic logic [7:0] pkt_byte(input logic [3:0] i, input logic [7:0] seq,
                                          input logic [15:0] m, input logic [15:0] s,
                                          input logic [31:0] v, input logic [7:0] sum);
    case (i)
      4'd0:    pkt_byte = HEADER_BYTE;
      4'd1:    pkt_byte = seq;
      4'd2:    pkt_byte = m[15:8];
      4'd3:    pkt_byte = m[7:0];
      4'd4:    pkt_byte = s[15:8];
      4'd5:    pkt_byte = s[7:0];
      4'd6:    pkt_byte = v[31:24];
      4'd7:    pkt_byte = v[23:16];
      4'd8:    pkt_byte = v[15:8];
      4'd9:    pkt_byte = v[7:0];
      default: pkt_byte = sum;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    idx_next   = idx;
    csum_next  = csum;
    data_next  = tx.tx_data;
    valid_next = tx.tx_valid;
    last_next  = tx.tx_last;
    sent_next  = 1'b0;
    seq_next   = seq_num;
    drop_next  = drop_count;
    latch      = 1'b0;
    if (result_valid && state != IDLE && drop_count != 8'hFF)
      drop_next = drop_count + 8'd1;
    case (state)
      IDLE: begin
        if (result_valid) begin
          latch      = 1'b1;
          state_next = SEND;
          idx_next   = 4'd0;
          csum_next  = 8'd0;
          data_next  = HEADER_BYTE;
          valid_next = 1'b1;
          last_next  = 1'b0;
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (idx == CSUM_IDX) begin
            state_next = DONE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            sent_next  = 1'b1;
            seq_next   = seq_num + 8'd1;
          end else begin
            // The next byte is precomputed so tx_data leaves a flop, including the checksum.
            idx_next  = idx + 4'd1;
            csum_next = csum + tx.tx_data;
            data_next = pkt_byte(idx_next, seq_q, mean_q, sd_q, var_q, csum_next);
            last_next = (idx_next == CSUM_IDX);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      idx          <= 4'd0;
      csum         <= 8'd0;
      mean_q       <= 16'd0;
      sd_q         <= 16'd0;
      var_q        <= 32'd0;
      seq_q        <= 8'd0;
      tx.tx_data   <= 8'd0;
      tx.tx_valid  <= 1'b0;
      tx.tx_last   <= 1'b0;
      data_sent    <= 1'b0;
      seq_num      <= 8'd0;
      drop_count   <= 8'd0;
      result_ready <= 1'b1;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      csum         <= csum_next;
      tx.tx_data   <= data_next;
      tx.tx_valid  <= valid_next;
      tx.tx_last   <= last_next;
      data_sent    <= sent_next;
      seq_num      <= seq_next;
      drop_count   <= drop_next;
      result_ready <= (state_next == IDLE);
      if (latch) begin
        mean_q <= mean_in;
        sd_q   <= sd_in;
        var_q  <= var_in;
        seq_q  <= seq_num;
      end
    end
  end
endmodule
